// File: rtl/oka_pkg.sv
// rtl/oka_pkg.sv - shared types and helpers for the Karatsuba carry-less multiplier
//
// Purpose: FSM state encoding and the carry-less product width helper.
// Ports:   none (package).
package oka_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LO   = 3'd1,
      MID  = 3'd2,
      HI   = 3'd3,
      RED  = 3'd4,
      DONE = 3'd5
   } state_t;

   // An n x n carry-less product has degree at most 2n-2.
   function automatic int clmul_width(input int n);
      return 2 * n - 1;
   endfunction

endpackage

// File: rtl/clmul_comb.sv
// rtl/clmul_comb.sv - combinational N x N carry-less multiplier core
//
// Purpose: z = a * b over GF(2)[x], bit i = coefficient of x^i.
// Ports:
//   a  in  N               operand a
//   b  in  N               operand b
//   z  out clmul_width(N)  product
module clmul_comb
   import oka_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N-1:0]              a,
   input  logic [N-1:0]              b,
   output logic [clmul_width(N)-1:0] z
);

   always_comb begin
      z = '0;
      for (int i = 0; i < N; i++) begin
         if (b[i]) begin
            z = z ^ ({{(N-1){1'b0}}, a} << i);
         end
      end
   end

endmodule

// File: rtl/oka_clmul_seq.sv
// rtl/oka_clmul_seq.sv - sequential one-level Karatsuba carry-less multiplier with optional reduction
//
// Purpose: one shared H x H core computes z0, z1, z2 over three cycles; the
//          product is optionally reduced modulo x^W + in_poly.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operand strobe
//   in_ready   out  1      high only in IDLE
//   in_a       in   W      operand a
//   in_b       in   W      operand b
//   in_mode    in   1      0: full product, 1: reduce mod x^W + in_poly
//   in_poly    in   W      low coefficients of the monic modulus
//   out_valid  out  1      result strobe, high only in DONE
//   out_ready  in   1      downstream accepts
//   out_y      out  2W-1   product or remainder
module oka_clmul_seq
   import oka_pkg::*;
#(
   parameter  int W = 32,
   localparam int H = W / 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   input  logic           in_mode,
   input  logic [W-1:0]   in_poly,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-2:0] out_y
);

   state_t         state;
   state_t         state_nxt;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   poly_q;
   logic           mode_q;
   logic [2*W-2:0] acc;
   logic [2*H-2:0] mid;
   logic [H-1:0]   op_a;
   logic [H-1:0]   op_b;
   logic [2*H-2:0] z;
   logic [2*H-2:0] mid_term;
   logic [2*W-2:0] hi_acc;

   // Fold the top W-1 coefficients back into the low W using x^W == poly.
   function automatic logic [2*W-2:0] fold(input logic [2*W-2:0] p,
                                           input logic [W-1:0]   poly);
      logic [2*W-2:0] r;
      r = p;
      for (int k = 2*W-2; k >= W; k--) begin
         if (r[k]) begin
            r    = r ^ ({{(W-1){1'b0}}, poly} << (k - W));
            r[k] = 1'b0;
         end
      end
      return r;
   endfunction

   clmul_comb #(.N(H)) u_core (
      .a (op_a),
      .b (op_b),
      .z (z)
   );

   // In HI, acc still holds z0 and z carries z2; overlap-free recombination.
   assign mid_term = mid ^ acc[2*H-2:0] ^ z;
   assign hi_acc   = acc ^ ({{W{1'b0}}, mid_term} << H) ^ ({{W{1'b0}}, z} << W);
   assign out_y    = acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = LO;
         LO:      state_nxt = MID;
         MID:     state_nxt = HI;
         HI:      state_nxt = mode_q ? RED : DONE;
         RED:     state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      op_a      = a_q[H-1:0];
      op_b      = b_q[H-1:0];
      case (state)
         MID: begin
            op_a = a_q[H-1:0] ^ a_q[W-1:H];
            op_b = b_q[H-1:0] ^ b_q[W-1:H];
         end
         HI: begin
            op_a = a_q[W-1:H];
            op_b = b_q[W-1:H];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         poly_q <= '0;
         mode_q <= 1'b0;
         acc    <= '0;
         mid    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q    <= in_a;
                  b_q    <= in_b;
                  poly_q <= in_poly;
                  mode_q <= in_mode;
               end
            end
            LO:      acc <= {{W{1'b0}}, z};
            MID:     mid <= z;
            HI:      acc <= hi_acc;
            RED:     acc <= fold(acc, poly_q);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_oka_clmul_seq.sv
// tb/tb_oka_clmul_seq.sv - directed and random bench for oka_clmul_seq at W=8, 16 and 32
//
// Purpose: three instances run in lockstep on shared control; each result is
//          compared against a bench-side schoolbook model or constant.
// Ports:   none (top-level bench).
module tb_oka_clmul_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_mode;
   logic        out_ready;
   logic [31:0] a32, b32, p32;
   logic [15:0] a16, b16, p16;
   logic [7:0]  a8, b8, p8;
   logic        ready32, ready16, ready8;
   logic        ov32, ov16, ov8;
   logic [62:0] y32;
   logic [30:0] y16;
   logic [14:0] y8;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   oka_clmul_seq #(.W(32)) u32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready32),
      .in_a(a32), .in_b(b32), .in_mode(in_mode), .in_poly(p32),
      .out_valid(ov32), .out_ready(out_ready), .out_y(y32)
   );

   oka_clmul_seq #(.W(16)) u16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready16),
      .in_a(a16), .in_b(b16), .in_mode(in_mode), .in_poly(p16),
      .out_valid(ov16), .out_ready(out_ready), .out_y(y16)
   );

   oka_clmul_seq #(.W(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready8),
      .in_a(a8), .in_b(b8), .in_mode(in_mode), .in_poly(p8),
      .out_valid(ov8), .out_ready(out_ready), .out_y(y8)
   );

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input int w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         if (b[i]) r = r ^ ({32'd0, a} << i);
      end
      return r;
   endfunction

   // Long division by the full modulus x^w + poly.
   function automatic logic [63:0] ref_mod(input logic [63:0] p, input logic [31:0] poly, input int w);
      logic [63:0] m;
      m = {32'd0, poly} | (64'd1 << w);
      for (int k = 2*w-2; k >= w; k--) begin
         if (p[k]) p = p ^ (m << (k - w));
      end
      return p;
   endfunction

   // Presents operands for one cycle, scrambles inputs after the accept edge,
   // then waits (bounded) for out_valid. lat counts edges from the edge after
   // which in_valid was driven.
   task automatic run_op(output int lat);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      a32 = $urandom; b32 = $urandom; p32 = $urandom;
      a16 = 16'($urandom); b16 = 16'($urandom); p16 = 16'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); p8 = 8'($urandom);
      in_mode = 1'($urandom);
      while (!ov32 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_op();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
      a32 = '0; b32 = '0; p32 = '0; a16 = '0; b16 = '0; p16 = '0; a8 = '0; b8 = '0; p8 = '0;
      repeat (3) @(posedge clk);
      #1;
      vecs++; if (ready32 !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", ready32); end
      vecs++; if (ov32 !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", ov32); end
      vecs++; if (y32 !== 63'd0) begin errs++; $display("FAIL reset_out_y got %h want 0", y32); end
      rst = 1'b0;
   endtask

   task automatic test_small_mode0();
      int lat;
      a32 = 32'h3; b32 = 32'h3; in_mode = 1'b0;
      run_op(lat);
      vecs++; if (lat !== 4) begin errs++; $display("FAIL small_latency got %0d want 4", lat); end
      vecs++; if ({1'b0, y32} !== 64'h5) begin errs++; $display("FAIL small_y got %h want 5", y32); end
      release_op();
   endtask

   task automatic test_all_ones();
      int lat;
      a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; in_mode = 1'b0;
      run_op(lat);
      vecs++; if ({1'b0, y32} !== 64'h5555_5555_5555_5555) begin
         errs++; $display("FAIL all_ones_y got %h want 5555555555555555", y32);
      end
      release_op();
   endtask

   task automatic test_w8_aes();
      int lat;
      a8 = 8'h57; b8 = 8'h83; in_mode = 1'b0;
      run_op(lat);
      vecs++; if (lat !== 4) begin errs++; $display("FAIL w8_mode0_latency got %0d want 4", lat); end
      vecs++; if (y8 !== 15'h2B79) begin errs++; $display("FAIL w8_mode0_y got %h want 2b79", y8); end
      release_op();
      a8 = 8'h57; b8 = 8'h83; p8 = 8'h1B; in_mode = 1'b1;
      run_op(lat);
      vecs++; if (lat !== 5) begin errs++; $display("FAIL w8_mode1_latency got %0d want 5", lat); end
      vecs++; if (y8 !== 15'h00C1) begin errs++; $display("FAIL w8_mode1_y got %h want 00c1", y8); end
      release_op();
   endtask

   task automatic test_boundaries();
      int lat;
      a32 = 32'h0; b32 = 32'hCAFE_F00D; a16 = 16'h1234; b16 = 16'h0; in_mode = 1'b0;
      run_op(lat);
      vecs++; if (y32 !== 63'd0) begin errs++; $display("FAIL zero_a_y got %h want 0", y32); end
      vecs++; if (y16 !== 31'd0) begin errs++; $display("FAIL zero_b_y got %h want 0", y16); end
      release_op();
      a8 = 8'h57; b8 = 8'h83; p8 = 8'h00; in_mode = 1'b1;
      run_op(lat);
      vecs++; if (y8 !== 15'h0079) begin errs++; $display("FAIL poly0_y got %h want 0079", y8); end
      release_op();
   endtask

   task automatic test_stall();
      int lat;
      logic [62:0] snap;
      a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678; in_mode = 1'b0;
      run_op(lat);
      snap = y32;
      vecs++; if ({1'b0, snap} !== ref_mul(32'hDEAD_BEEF, 32'h1234_5678, 32)) begin
         errs++; $display("FAIL stall_y got %h want %h", snap, ref_mul(32'hDEAD_BEEF, 32'h1234_5678, 32));
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         vecs++; if (ov32 !== 1'b1) begin errs++; $display("FAIL stall_out_valid cyc %0d got %b want 1", i, ov32); end
         vecs++; if (ready32 !== 1'b0) begin errs++; $display("FAIL stall_in_ready cyc %0d got %b want 0", i, ready32); end
         vecs++; if (y32 !== snap) begin errs++; $display("FAIL stall_y_stable cyc %0d got %h want %h", i, y32, snap); end
      end
      release_op();
      vecs++; if (ready32 !== 1'b1) begin errs++; $display("FAIL release_in_ready got %b want 1", ready32); end
      vecs++; if (ov32 !== 1'b0) begin errs++; $display("FAIL release_out_valid got %b want 0", ov32); end
   endtask

   task automatic test_reset_mid_op();
      int lat;
      a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; in_mode = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vecs++; if (ready32 !== 1'b1) begin errs++; $display("FAIL midrst_in_ready got %b want 1", ready32); end
      vecs++; if (ov32 !== 1'b0) begin errs++; $display("FAIL midrst_out_valid got %b want 0", ov32); end
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         vecs++; if (ov32 !== 1'b0) begin errs++; $display("FAIL midrst_no_result cyc %0d got %b want 0", i, ov32); end
      end
      a32 = 32'h2; b32 = 32'h2; in_mode = 1'b0;
      run_op(lat);
      vecs++; if ({1'b0, y32} !== 64'h4) begin errs++; $display("FAIL midrst_next_y got %h want 4", y32); end
      release_op();
   endtask

   task automatic test_random();
      logic [31:0] ra, rb, rp;
      logic [15:0] ra16, rb16, rp16;
      logic [7:0]  ra8, rb8, rp8;
      logic        rm;
      logic [63:0] e32, e16, e8;
      bit          got;
      for (int n = 0; n < 1000; n++) begin
         ra = $urandom; rb = $urandom; rp = $urandom;
         ra16 = 16'($urandom); rb16 = 16'($urandom); rp16 = 16'($urandom);
         ra8 = 8'($urandom); rb8 = 8'($urandom); rp8 = 8'($urandom);
         rm = 1'($urandom);
         e32 = ref_mul(ra, rb, 32);
         e16 = ref_mul({16'd0, ra16}, {16'd0, rb16}, 16);
         e8  = ref_mul({24'd0, ra8}, {24'd0, rb8}, 8);
         if (rm) begin
            e32 = ref_mod(e32, rp, 32);
            e16 = ref_mod(e16, {16'd0, rp16}, 16);
            e8  = ref_mod(e8, {24'd0, rp8}, 8);
         end
         vecs++; if (ready32 !== 1'b1) begin errs++; $display("FAIL rnd_in_ready op %0d got %b want 1", n, ready32); end
         a32 = ra; b32 = rb; p32 = rp; a16 = ra16; b16 = rb16; p16 = rp16;
         a8 = ra8; b8 = rb8; p8 = rp8; in_mode = rm;
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         a32 = $urandom; b32 = $urandom; p32 = $urandom; in_mode = 1'($urandom);
         got = 1'b0;
         for (int c = 0; c < 60 && !got; c++) begin
            out_ready = 1'($urandom);
            if (ov32 && out_ready) begin
               vecs++; if ({1'b0, y32} !== e32) begin errs++; $display("FAIL rnd_w32 op %0d got %h want %h", n, y32, e32); end
               vecs++; if ({33'd0, y16} !== e16) begin errs++; $display("FAIL rnd_w16 op %0d got %h want %h", n, y16, e16); end
               vecs++; if ({49'd0, y8} !== e8) begin errs++; $display("FAIL rnd_w8 op %0d got %h want %h", n, y8, e8); end
               got = 1'b1;
            end
            @(posedge clk); #1;
         end
         out_ready = 1'b0;
         vecs++; if (got !== 1'b1) begin errs++; $display("FAIL rnd_timeout op %0d got no result want one", n); end
         vecs++; if (ov32 !== 1'b0) begin errs++; $display("FAIL rnd_duplicate op %0d got out_valid %b want 0", n, ov32); end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_small_mode0();
      test_all_ones();
      test_w8_aes();
      test_boundaries();
      test_stall();
      test_reset_mid_op();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
